// File: rtl/csel_sub_seq.sv
// Sequential carry-select subtractor: one CHUNK-bit slice per cycle, LSB first, valid/ready handshake.
// Optional status flags (zero, ovf) are enabled by defining CSEL_SUB_FLAGS_EN.
module csel_sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef CSEL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_a, r_b, r_diff;
  logic               r_carry, r_borrow;
  logic [IDXW-1:0]    r_idx;
  logic               w_accept, w_last;
  logic [CHUNK-1:0]   w_a_sl, w_nb_sl;
  logic [CHUNK:0]     w_sum0, w_sum1, w_sel;
  logic               w_cout;
  logic [WIDTH-1:0]   w_diff_next;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this combinational block from inferring a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == IDXW'(NCHUNK - 1));

  // Operands shift right each RUN cycle, so the active slice is always the low CHUNK bits.
  assign w_a_sl  = r_a[CHUNK-1:0];
  assign w_nb_sl = ~r_b[CHUNK-1:0];

  // Both carry-in candidates are formed in parallel; the registered carry picks one.
  assign w_sum0 = {1'b0, w_a_sl} + {1'b0, w_nb_sl};
  assign w_sum1 = {1'b0, w_a_sl} + {1'b0, w_nb_sl} + (CHUNK+1)'(1);
  assign w_sel  = r_carry ? w_sum1 : w_sum0;
  assign w_cout = w_sel[CHUNK];

  always_comb begin
    w_diff_next = r_diff;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDXW'(k)) w_diff_next[k*CHUNK +: CHUNK] = w_sel[CHUNK-1:0];
    end
  end

`ifdef CSEL_SUB_FLAGS_EN
  logic w_c_into_msb;
  logic r_zero, r_ovf;

  // Carry into the operand MSB recovered from the slice's top sum bit.
  assign w_c_into_msb = w_a_sl[CHUNK-1] ^ w_nb_sl[CHUNK-1] ^ w_sel[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_zero <= (w_diff_next == '0);
      r_ovf  <= w_c_into_msb ^ w_cout;
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`endif

  // Datapath: operand latches, result assembly, inter-slice carry and slice index.
  // NOTE: every datapath register is plain flops (no memory array), so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_carry  <= 1'b1;
      r_borrow <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a     <= a;
          r_b     <= b;
          r_diff  <= '0;
          r_carry <= 1'b1;
          r_idx   <= '0;
        end
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_diff  <= w_diff_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) r_borrow <= ~w_cout;
        end
        default: ;
      endcase
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_csel_sub_seq.sv
// Self-checking bench for csel_sub_seq: directed vectors, an arithmetic scoreboard model and literal checks.
// Flag ports are exercised when CSEL_SUB_FLAGS_EN is defined.
module tb_csel_sub_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef CSEL_SUB_FLAGS_EN
  logic             zero, ovf;
`endif

  csel_sub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef CSEL_SUB_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             br;
    logic             z;
    logic             v;
    int               acc;
    bit               lat_done;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain modular subtraction plus unsigned/signed comparisons.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int acc);
    exp_t e;
    e.d        = x - y;
    e.br       = (x < y);
    e.z        = (e.d == '0);
    e.v        = (x[WIDTH-1] != y[WIDTH-1]) && (e.d[WIDTH-1] != x[WIDTH-1]);
    e.acc      = acc;
    e.lat_done = 1'b0;
    return e;
  endfunction

  // Handshake monitor: record accepts, retire consumed results.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(a, b, cyc + 1));
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) exp_q.delete(0);
  end

  // Compare process: every cycle a result is presented, it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("sb_diff", 64'(diff), 64'(exp_q[0].d));
        check("sb_borrow", 64'(borrow), 64'(exp_q[0].br));
        check("sb_in_ready_low", 64'(in_ready), 64'd0);
`ifdef CSEL_SUB_FLAGS_EN
        check("sb_zero", 64'(zero), 64'(exp_q[0].z));
        check("sb_ovf", 64'(ovf), 64'(exp_q[0].v));
`endif
        if (!exp_q[0].lat_done) begin
          check("sb_latency", 64'(cyc - exp_q[0].acc), 64'(NCHUNK));
          exp_q[0].lat_done = 1'b1;
        end
      end
    end
  end

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  // Presents one operand pair, scrambles inputs after the accept, returns on the first out_valid cycle.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic rdy);
    @(negedge clk);
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    out_ready = rdy;
    check("accept_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    wait_valid();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #23;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", 64'(diff), 64'd0);
    check("rst_borrow", 64'(borrow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Carry ripples through all slices.
    run_op(32'h0000_0005, 32'h0000_0003, 1'b1);
    check("t1_diff", 64'(diff), 64'h0000_0002);
    check("t1_borrow", 64'(borrow), 64'd0);

    // Equal operands, then a back-to-back op one cycle after the release edge.
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1);
    check("t4_diff", 64'(diff), 64'h0);
    check("t4_borrow", 64'(borrow), 64'd0);
`ifdef CSEL_SUB_FLAGS_EN
    check("t4_zero", 64'(zero), 64'd1);
`endif
    run_op(32'h0000_0010, 32'h0000_0020, 1'b1);
    check("t4b_diff", 64'(diff), 64'hFFFF_FFF0);
    check("t4b_borrow", 64'(borrow), 64'd1);

    // Backpressure: result held while new operands wait on in_valid.
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0);
    a        = 32'h8000_0000;
    b        = 32'h0000_0001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_diff", 64'(diff), 64'hFFFF_FFFF);
      check("bp_borrow", 64'(borrow), 64'd1);
`ifdef CSEL_SUB_FLAGS_EN
      check("bp_zero", 64'(zero), 64'd0);
      check("bp_ovf", 64'(ovf), 64'd0);
`endif
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("bp_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    wait_valid();
    check("t3_diff", 64'(diff), 64'h7FFF_FFFF);
    check("t3_borrow", 64'(borrow), 64'd0);
`ifdef CSEL_SUB_FLAGS_EN
    check("t3_ovf", 64'(ovf), 64'd1);
    check("t3_zero", 64'(zero), 64'd0);
`endif

    // Reset in the middle of RUN, after three slices have been written.
    @(negedge clk);
    a        = 32'hFFFF_FFFF;
    b        = 32'h0000_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_run_partial", 64'(diff[11:0]), 64'hFFF);
    check("mid_run_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_diff", 64'(diff), 64'd0);
    check("async_rst_borrow", 64'(borrow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    run_op(32'd7, 32'd7, 1'b1);
    check("t6_diff", 64'(diff), 64'h0);
    check("t6_borrow", 64'(borrow), 64'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
